// File: rtl/ram_init_1rw1r.sv
// One read/write plus one read-only synchronous RAM with per-byte write strobes,
// read-first port 0, optional port-1 write bypass and a post-reset clear sequencer.
module ram_init_1rw1r #(
    parameter int unsigned       DBITS          = 64,
    parameter int unsigned       ABITS          = 8,
    parameter int unsigned       CLEAR_ON_RESET = 1,
    parameter logic [DBITS-1:0]  INIT_VALUE     = '0,
    parameter int unsigned       BYPASS         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [ABITS-1:0]     addr0,
    input  logic                 re0,
    input  logic                 we0,
    input  logic [DBITS/8-1:0]   wstrb0,
    input  logic [DBITS-1:0]     wr0,
    output logic [DBITS-1:0]     rd0,
    output logic                 rvalid0,
    input  logic [ABITS-1:0]     addr1,
    input  logic                 re1,
    output logic [DBITS-1:0]     rd1,
    output logic                 rvalid1
);

    localparam int unsigned NBYTES = DBITS / 8;
    localparam int unsigned DEPTH  = 32'(1) << ABITS;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    logic [DBITS-1:0]  mem [DEPTH];

    state_t            state_q, state_d;
    logic [ABITS-1:0]  ctr_q, ctr_d;
    logic              ready_d;
    logic [NBYTES-1:0] wen_c;
    logic [ABITS-1:0]  waddr_c;
    logic [DBITS-1:0]  wdata_c;
    logic              acc0_c, acc1_c, collide_c;
    logic [DBITS-1:0]  merged1_c;

    assign acc0_c    = ready & re0;
    assign acc1_c    = ready & re1;
    assign collide_c = (BYPASS != 0) && (addr1 == waddr_c);

    // Next state and the single shared write port (clear sequencer or port 0)
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        wen_c   = '0;
        waddr_c = addr0;
        wdata_c = wr0;
        unique case (state_q)
            S_CLEAR: begin
                wen_c   = '1;
                waddr_c = ctr_q;
                wdata_c = INIT_VALUE;
                ctr_d   = ctr_q + ABITS'(1);
                if (ctr_q == ABITS'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ready && we0) begin
                    wen_c = wstrb0;
                end
            end
            default: ;
        endcase
        ready_d = (state_d == S_RUN);
    end

    // Bypass merge applied after the array read, before the port-1 register
    always_comb begin
        merged1_c = mem[addr1];
        for (int i = 0; i < NBYTES; i++) begin
            if (collide_c && wen_c[i]) begin
                merged1_c[8*i +: 8] = wdata_c[8*i +: 8];
            end
        end
    end

    // Array writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wen_c[i]) begin
                    mem[waddr_c][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            ctr_q   <= '0;
            ready   <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            ready   <= ready_d;
            rvalid0 <= acc0_c;
            rvalid1 <= acc1_c;
            if (acc0_c) begin
                rd0 <= mem[addr0];
            end
            if (acc1_c) begin
                rd1 <= merged1_c;
            end
        end
    end

endmodule
